hazard_ctrl: RTL

Pipeline hazard controller for the five-stage core. It drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves four conditions: load-use hazards, taken branches/jumps resolved in ID, HI/LO reads while the multi-cycle multiply/divide unit is busy, and data-memory wait states. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_ctrl_md_timer.sv | 50 +++++
 rtl/hazard_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Common pipeline definitions shared by the hazard controller and its timer.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_md_timer.sv
// Tracks the multi-cycle multiply/divide unit; md_busy is high while a result is pending.
module hazard_ctrl_md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  input  logic hold_i,
  output logic md_busy_o
);

  localparam int unsigned MD_CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // A memory wait freezes the EX stage, so neither a start nor a countdown step is taken.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (!hold_i) begin
      if (md_start_i) begin
        state_d  = MD_BUSY;
        md_cnt_d = CNT_LOAD;
      end else if (state_q == MD_BUSY) begin
        md_cnt_d = md_cnt_q - CNT_ONE;
        if (md_cnt_q == CNT_ONE) begin
          state_d = IDLE;
        end
      end
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);

endmodule : hazard_ctrl_md_timer

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush steering for the five-stage core plus a stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic             id_md_read,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_md_start,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             load_use;
  logic             md_hazard;
  logic [CNT_W-1:0] stall_q, stall_d;

  hazard_ctrl_md_timer #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_i (ex_md_start),
    .hold_i     (dmem_wait),
    .md_busy_o  (md_busy)
  );

  assign load_use  = ex_memread && (ex_rt != ZERO_REG) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign md_hazard = md_busy && id_md_read;

  // Priority: reset, memory wait, data hazard bubble, taken-branch squash, normal flow.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (dmem_wait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (load_use || md_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule : hazard_ctrl
